hyst_filter: RTL and testbench
==============================

# hyst_filter

Multi-channel majority filter with hysteresis for debouncing slow or noisy status inputs (fault lines, link-detect, GPIO pins) before they reach control logic. Each channel keeps a saturating up/down vote counter, advanced only on a sample strobe, and drives a registered output that asserts at a set threshold and deasserts at a lower release threshold. A parameterised sticky mode gives latch-until-clear behaviour for fault capture. Single-cycle rise and fall pulses are provided per channel.

## Interface
- NUM_CHANNELS, 8: number of independent filter channels (≥1).
- CNT_WIDTH, 4: vote counter width per channel (≥2); counter range 0 .. 2^CNT_WIDTH-1.
- STICKY, 0: 0 = hysteresis mode; 1 = output, once set, holds until clear_i or clr_i.

- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- clr_i  in  1  synchronous clear of all channel state.
- clear_i  in  NUM_CHANNELS  per-channel synchronous clear.
- sample_i  in  1  sample strobe; counters move only when high.
- d_i  in  NUM_CHANNELS  raw inputs, already synchronised to clk_i.
- thresh_set_i  in  CNT_WIDTH  set threshold, shared by all channels.
- thresh_rel_i  in  CNT_WIDTH  release threshold, shared by all channels.
- q_o  out  NUM_CHANNELS  filtered outputs, registered.
- rise_o  out  NUM_CHANNELS  one-cycle pulse when q_o[i] goes 0→1, registered.
- fall_o  out  NUM_CHANNELS  one-cycle pulse when q_o[i] goes 1→0, registered.

## Operation
- Per channel i: counter cnt[i], output state q[i], pulse regs rise[i] and fall[i].
- Counter update, only when sample_i=1: d_i[i]=1 gives cnt+1, saturating at 2^CNT_WIDTH-1. d_i[i]=0 gives cnt-1, saturating at 0. No wrap in either direction.
- Counter holds when sample_i=0. Counters keep running while q is set, including in sticky mode.
- State decision uses the registered counter cnt_q, never cnt_d:
  - IDLE (q=0) → ACTIVE (q=1) when cnt_q ≥ thresh_set_i.
  - ACTIVE → IDLE when cnt_q ≤ thresh_rel_i and STICKY=0.
  - With STICKY=1, ACTIVE is left only via clear.
- Comparisons are unsigned and CNT_WIDTH bits wide.
- Legal configuration is thresh_set_i > thresh_rel_i. The bench asserts this whenever sample_i=1.
- If the configuration is illegal, the IDLE→ACTIVE check is evaluated first and the output toggles at most once per cycle. The behaviour is deterministic but is not a use case.
- thresh_set_i=0 makes q set one cycle after any clear. This is legal.
- Per-channel clear (clear_i[i]) or global clear (clr_i) forces the following on the next edge: cnt=0, q=0, rise=0, fall=0.
  - A clear never produces a fall pulse.
  - A clear overrides any simultaneous sample or threshold event on that channel.
- Thresholds may change at any time. The new value applies to the decision in the same cycle it is presented.
- Channels are fully independent; the only shared inputs are the strobe, the thresholds and clr_i.

## Timing
- Reset (rst_ni=0) is asynchronous. It forces every counter, q_o, rise_o and fall_o to 0 immediately and holds them there while asserted.
- Counter latency: a sample at edge k is visible in cnt_q after edge k.
- Output latency: when cnt_q first meets the set condition in cycle k, q_o rises after edge k+1. Worst case is therefore two edges from the qualifying sample to q_o.
- Release has the same latency, one edge after the cnt_q condition.
- rise_o[i] and fall_o[i] are high for exactly the one cycle in which q_o[i] first shows its new value. They are never both high.
- Back-to-back toggles are allowed: with thresholds 1 and 0, the output can set and release on consecutive cycles.
- No combinational path runs from any input to any output.
- Deasserting reset mid-operation restarts all channels from IDLE with cnt=0.

## Test plan
- Reset/idle: hold rst_ni=0, drive d_i='1 with sample_i=1 → all outputs 0. Release reset with sample_i=0 for 10 cycles → q_o=0, cnt stays 0.
- Set with hysteresis (STICKY=0, CNT_WIDTH=4, set=10, rel=3, ch0):
  - 10 samples of d=1 → q_o[0] rises two edges after the 10th sample, with rise_o[0] high for 1 cycle.
  - Then 6 samples of d=0 (cnt 10→4) → q_o[0] stays 1.
  - A 7th sample (cnt=3) → q_o[0] falls with a fall_o[0] pulse.
- Saturation: 20 samples of d=1 → cnt holds at 15. Then 16 samples of d=0 → cnt 15→0 and holds at 0, with exactly one rise and one fall pulse over the whole sequence.
- Sticky mode (STICKY=1, set=5): reach q=1, then 15 samples of d=0 → q_o stays 1. Pulse clear_i[2] on that channel → q_o and cnt go to 0 next edge, with no fall_o pulse.
- Clear priority and independence:
  - Assert clear_i[1] in the same cycle ch1 would set → ch1 stays 0.
  - Ch0, sampled identically, sets normally.
  - Then clr_i → all channels 0 next edge.
- Async reset mid-operation: assert rst_ni mid-cycle while q_o=8'hA5 → outputs go to 0 without waiting for a clock edge. After release, a normal set sequence on ch3 behaves as in the set-with-hysteresis case.

Source files
------------

// File: rtl/hyst_filter.sv
// Multi-channel majority filter with hysteresis: each channel owns a saturating
// vote counter advanced on the sample strobe and a registered set/release output.

module hyst_filter_ch #(
    parameter int CNT_WIDTH = 4,
    parameter bit STICKY    = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 sample_i,
    input  logic                 d_i,
    input  logic [CNT_WIDTH-1:0] thresh_set_i,
    input  logic [CNT_WIDTH-1:0] thresh_rel_i,
    output logic                 q_o,
    output logic                 rise_o,
    output logic                 fall_o
);
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 rise_q, fall_q;

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (sample_i) begin
            if (d_i && cnt_q != CNT_MAX)
                cnt_d = cnt_q + 1'b1;
            else if (!d_i && cnt_q != '0)
                cnt_d = cnt_q - 1'b1;
        end
        // Decision looks at the registered count, so an edge costs one extra cycle.
        case (state_q)
            IDLE:    if (cnt_q >= thresh_set_i) state_d = ACTIVE;
            ACTIVE:  if (!STICKY && cnt_q <= thresh_rel_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else if (clr_i) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rise_q  <= (state_q == IDLE)   && (state_d == ACTIVE);
            fall_q  <= (state_q == ACTIVE) && (state_d == IDLE);
        end
    end

    assign q_o    = (state_q == ACTIVE);
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

module hyst_filter #(
    parameter int NUM_CHANNELS = 8,
    parameter int CNT_WIDTH    = 4,
    parameter bit STICKY       = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic [NUM_CHANNELS-1:0] clear_i,
    input  logic                    sample_i,
    input  logic [NUM_CHANNELS-1:0] d_i,
    input  logic [CNT_WIDTH-1:0]    thresh_set_i,
    input  logic [CNT_WIDTH-1:0]    thresh_rel_i,
    output logic [NUM_CHANNELS-1:0] q_o,
    output logic [NUM_CHANNELS-1:0] rise_o,
    output logic [NUM_CHANNELS-1:0] fall_o
);
    logic [NUM_CHANNELS-1:0] ch_clr;

    assign ch_clr = {NUM_CHANNELS{clr_i}} | clear_i;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        hyst_filter_ch #(
            .CNT_WIDTH (CNT_WIDTH),
            .STICKY    (STICKY)
        ) u_ch (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .clr_i        (ch_clr[i]),
            .sample_i     (sample_i),
            .d_i          (d_i[i]),
            .thresh_set_i (thresh_set_i),
            .thresh_rel_i (thresh_rel_i),
            .q_o          (q_o[i]),
            .rise_o       (rise_o[i]),
            .fall_o       (fall_o[i])
        );
    end
endmodule

// File: tb/tb_hyst_filter.sv
// Bench for hyst_filter: hysteresis and sticky instances share stimulus; a cycle
// model feeds a scoreboard queue, and hand tables pin down the key sequences.

module tb_hyst_filter;
    localparam int N = 8;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr;
    logic [N-1:0] clear;
    logic         sample;
    logic [N-1:0] d;
    logic [W-1:0] ts, tr;
    logic [N-1:0] q, rise, fall;
    logic [N-1:0] qs, rises, falls;

    always #5 clk = ~clk;

    hyst_filter #(.NUM_CHANNELS(N), .CNT_WIDTH(W), .STICKY(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .clear_i(clear), .sample_i(sample),
        .d_i(d), .thresh_set_i(ts), .thresh_rel_i(tr),
        .q_o(q), .rise_o(rise), .fall_o(fall)
    );

    hyst_filter #(.NUM_CHANNELS(N), .CNT_WIDTH(W), .STICKY(1'b1)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .clear_i(clear), .sample_i(sample),
        .d_i(d), .thresh_set_i(ts), .thresh_rel_i(tr),
        .q_o(qs), .rise_o(rises), .fall_o(falls)
    );

    always @(posedge clk)
        if (rst_n && sample)
            assert (ts > tr) else $error("illegal threshold configuration while sampling");

    typedef struct {
        logic [N-1:0] q, r, f, qs, rs, fs;
    } exp_t;

    typedef struct {
        logic d;
        logic smp;
        logic eq;
        logic er;
        logic ef;
    } vec_t;

    exp_t         sb[$];
    vec_t         tbl[20];
    int           mcnt[N];
    logic [N-1:0] mq, mqs;
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mcnt[i] = 0;
        mq  = '0;
        mqs = '0;
    endtask

    // Drive one cycle at the falling edge, predict the post-edge outputs, then compare.
    task automatic step(input logic [N-1:0] dv, input logic smp,
                        input logic [N-1:0] clrv, input logic gclr);
        exp_t e;
        int   nc;
        d = dv; sample = smp; clear = clrv; clr = gclr;
        e = '{default: '0};
        for (int i = 0; i < N; i++) begin
            if (gclr || clrv[i]) begin
                mcnt[i] = 0;
            end else begin
                nc = mcnt[i];
                if (smp) nc = dv[i] ? ((nc < 15) ? nc + 1 : 15) : ((nc > 0) ? nc - 1 : 0);
                e.q[i] = mq[i];
                if (!mq[i] && mcnt[i] >= int'(ts)) e.q[i] = 1'b1;
                else if (mq[i] && mcnt[i] <= int'(tr)) e.q[i] = 1'b0;
                e.qs[i] = mqs[i] | (mcnt[i] >= int'(ts));
                e.r[i]  = e.q[i] & ~mq[i];
                e.f[i]  = ~e.q[i] & mq[i];
                e.rs[i] = e.qs[i] & ~mqs[i];
                e.fs[i] = ~e.qs[i] & mqs[i];
                mcnt[i] = nc;
            end
        end
        mq  = e.q;
        mqs = e.qs;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk("sb_q", q, e.q);
        chk("sb_rise", rise, e.r);
        chk("sb_fall", fall, e.f);
        chk("sb_qs", qs, e.qs);
        chk("sb_rise_s", rises, e.rs);
        chk("sb_fall_s", falls, e.fs);
    endtask

    task automatic run_table(input int ch);
        for (int k = 0; k < 20; k++) begin
            step(N'(tbl[k].d) << ch, tbl[k].smp, '0, 1'b0);
            chk("hyst_q", N'(q[ch]), N'(tbl[k].eq));
            chk("hyst_rise", N'(rise[ch]), N'(tbl[k].er));
            chk("hyst_fall", N'(fall[ch]), N'(tbl[k].ef));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nr, nf, ridx, fidx;
        logic [W-1:0] r_tr;

        // set=10 rel=3: ten ones, idle, seven zeros, two idles
        for (int i = 0; i < 10; i++) tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 11; i < 18; i++) tbl[i] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset holds everything low even with active sampling
        rst_n = 1'b0; clr = 1'b0; clear = '0; sample = 1'b1; d = '1;
        ts = 4'd10; tr = 4'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_q", q, '0);
        chk("rst_rise", rise, '0);
        chk("rst_fall", fall, '0);
        chk("rst_qs", qs, '0);
        sample = 1'b0; d = '0;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 10; k++) step('0, 1'b0, '0, 1'b0);
        chk("idle_q", q, '0);

        // Hysteresis on ch0
        run_table(0);

        // Saturation on ch0 (cnt starts at 3): rise on 8th one, fall on 13th zero
        nr = 0; nf = 0; ridx = 0; fidx = 0;
        for (int j = 1; j <= 20; j++) begin
            step(8'h01, 1'b1, '0, 1'b0);
            if (rise[0]) begin nr++; ridx = j; end
            if (fall[0]) nf++;
        end
        for (int j = 1; j <= 16; j++) begin
            step(8'h00, 1'b1, '0, 1'b0);
            if (rise[0]) nr++;
            if (fall[0]) begin nf++; fidx = j; end
        end
        repeat (4) begin
            step(8'h00, 1'b0, '0, 1'b0);
            if (rise[0]) nr++;
            if (fall[0]) nf++;
        end
        chk("sat_rise_cnt", N'(nr), 8'd1);
        chk("sat_fall_cnt", N'(nf), 8'd1);
        chk("sat_rise_idx", N'(ridx), 8'd8);
        chk("sat_fall_idx", N'(fidx), 8'd13);
        // Counter must sit at 0: a fresh run of ten ones sets on the following edge
        repeat (20) step(8'h00, 1'b1, '0, 1'b0);
        ridx = 0;
        for (int j = 1; j <= 11; j++) begin
            step((j <= 10) ? 8'h01 : 8'h00, j <= 10, '0, 1'b0);
            if (rise[0]) ridx = j;
        end
        chk("floor_rise_idx", N'(ridx), 8'd11);
        step('0, 1'b0, '0, 1'b1);

        // Sticky on ch2, set=5
        ts = 4'd5; tr = 4'd3;
        repeat (5) step(8'h04, 1'b1, '0, 1'b0);
        step('0, 1'b0, '0, 1'b0);
        chk("sticky_set", N'(qs[2]), 8'd1);
        repeat (15) step(8'h00, 1'b1, '0, 1'b0);
        chk("sticky_hold", N'(qs[2]), 8'd1);
        chk("nonsticky_rel", N'(q[2]), 8'd0);
        step('0, 1'b0, 8'h04, 1'b0);
        chk("sticky_clr_q", N'(qs[2]), 8'd0);
        chk("sticky_clr_fall", N'(falls[2]), 8'd0);
        repeat (5) step(8'h04, 1'b1, '0, 1'b0);
        step('0, 1'b0, '0, 1'b0);
        chk("sticky_reset_cnt", N'(rises[2]), 8'd1);
        step('0, 1'b0, '0, 1'b1);

        // Clear beats a simultaneous set; neighbouring channel unaffected
        ts = 4'd3; tr = 4'd1;
        repeat (3) step(8'h03, 1'b1, '0, 1'b0);
        step('0, 1'b0, 8'h02, 1'b0);
        chk("clr_prio", q & 8'h03, 8'h01);
        step('0, 1'b0, '0, 1'b1);
        chk("gclr_all", q, '0);

        // Async reset mid-cycle with q=A5
        ts = 4'd5; tr = 4'd2;
        repeat (5) step(8'hA5, 1'b1, '0, 1'b0);
        step(8'h00, 1'b0, '0, 1'b0);
        chk("pre_rst_q", q, 8'hA5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_q", q, '0);
        chk("async_rst_rise", rise, '0);
        chk("async_rst_qs", qs, '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ts = 4'd10; tr = 4'd3;
        run_table(3);

        // Random traffic against the model, thresholds always legal
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                r_tr = W'($urandom_range(0, 13));
                tr = r_tr;
                ts = W'($urandom_range(int'(r_tr) + 1, 15));
            end
            step(N'($urandom), $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 15) == 0) ? N'($urandom) : '0,
                 $urandom_range(0, 63) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
